// File: rtl/h14tx_pkg.sv
// Shared types and constants for the HDMI 1.4 TX raster timing generator.
package h14tx_pkg;

  typedef enum logic [2:0] {
    Control       = 3'd0,
    VideoActive   = 3'd1,
    VideoPreamble = 3'd2,
    VideoGuard    = 3'd3,
    DataPreamble  = 3'd4,
    DataGuard     = 3'd5,
    DataActive    = 3'd6
  } period_t;

  typedef enum logic [2:0] {
    IslIdle       = 3'd0,
    IslPreamble   = 3'd1,
    IslLeadGuard  = 3'd2,
    IslData       = 3'd3,
    IslTrailGuard = 3'd4
  } isl_state_t;

  localparam int PreambleLen = 8;
  localparam int GuardLen    = 2;
  localparam int PacketLen   = 32;

endpackage

// File: rtl/h14tx_timings_gen_if.sv
// Raster/island bus between the timing generator (master) and the TMDS/packet side (slave).
interface h14tx_timings_gen_if #(
  parameter int BitWidth  = 11,
  parameter int BitHeight = 10
);
  import h14tx_pkg::*;

  logic                 enable;
  logic                 island_req;
  logic [4:0]           island_packets;
  logic [BitWidth-1:0]  x;
  logic [BitHeight-1:0] y;
  period_t              timings;
  logic                 hsync;
  logic                 vsync;
  logic                 island_grant;
  logic                 packet_start;
  logic                 frame_start;

  modport master (
    input  enable, island_req, island_packets,
    output x, y, timings, hsync, vsync, island_grant, packet_start, frame_start
  );

  modport slave (
    output enable, island_req, island_packets,
    input  x, y, timings, hsync, vsync, island_grant, packet_start, frame_start
  );

endinterface

// File: rtl/h14tx_island_sched.sv
// Data-island scheduler: grants a pending island at IslandStart and walks
// preamble / guard / packets / guard. Exposes next-cycle period for the top to register.
module h14tx_island_sched
  import h14tx_pkg::*;
#(
  parameter int BitWidth    = 11,
  parameter int IslandStart = 1300,
  parameter int MaxPackets  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [BitWidth-1:0] x_d,
  input  logic                island_req,
  input  logic [4:0]          island_packets,
  output logic                isl_act_d,
  output period_t             isl_per_d,
  output logic                grant_q,
  output logic                pstart_q
);

  localparam logic [BitWidth-1:0] StartX = BitWidth'(IslandStart);
  localparam logic [4:0]          MaxPk  = 5'(MaxPackets);

  isl_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, pkt_q, pkt_d, npkt_q, npkt_d;
  logic       grant_d, pstart_d;
  logic       pk_ok;

  assign pk_ok = (island_packets != 5'd0) && (island_packets <= MaxPk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IslIdle;
      cnt_q    <= '0;
      pkt_q    <= '0;
      npkt_q   <= '0;
      grant_q  <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      npkt_q   <= npkt_d;
      grant_q  <= grant_d;
      pstart_q <= pstart_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    npkt_d  = npkt_q;
    if (enable) begin
      case (state_q)
        IslIdle:
          // x_d == StartX with enable high means x is crossing StartX-1 -> StartX
          if (x_d == StartX && island_req && pk_ok) begin
            state_d = IslPreamble;
            cnt_d   = '0;
            npkt_d  = island_packets;
          end
        IslPreamble:
          if (cnt_q == 5'(PreambleLen-1)) begin
            state_d = IslLeadGuard;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 5'd1;
        IslLeadGuard:
          if (cnt_q == 5'(GuardLen-1)) begin
            state_d = IslData;
            cnt_d   = '0;
            pkt_d   = '0;
          end else cnt_d = cnt_q + 5'd1;
        IslData:
          if (cnt_q == 5'(PacketLen-1)) begin
            cnt_d = '0;
            if (pkt_q == npkt_q - 5'd1) state_d = IslTrailGuard;
            else                        pkt_d   = pkt_q + 5'd1;
          end else cnt_d = cnt_q + 5'd1;
        IslTrailGuard:
          if (cnt_q == 5'(GuardLen-1)) begin
            state_d = IslIdle;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 5'd1;
        default: state_d = IslIdle;
      endcase
    end
  end

  always_comb begin
    isl_act_d = (state_d != IslIdle);
    case (state_d)
      IslPreamble:                 isl_per_d = DataPreamble;
      IslLeadGuard, IslTrailGuard: isl_per_d = DataGuard;
      IslData:                     isl_per_d = DataActive;
      default:                     isl_per_d = Control;
    endcase
    // pulses freeze during a stall so they can reappear once enable returns
    grant_d  = enable ? (state_q == IslIdle && state_d == IslPreamble) : grant_q;
    pstart_d = enable ? (state_d == IslData && cnt_d == 5'd0)          : pstart_q;
  end

endmodule

// File: rtl/h14tx_timings_gen.sv
// HDMI 1.4 TX raster timing generator: pixel/line counters, registered sync,
// period classification and data-island scheduling, all aligned to current (x,y).
module h14tx_timings_gen
  import h14tx_pkg::*;
#(
  parameter int   BitWidth     = 11,
  parameter int   BitHeight    = 10,
  parameter int   FrameWidth   = 1650,
  parameter int   FrameHeight  = 750,
  parameter int   ActiveWidth  = 1280,
  parameter int   ActiveHeight = 720,
  parameter int   HSyncStart   = 1390,
  parameter int   HSyncWidth   = 40,
  parameter int   VSyncStart   = 725,
  parameter int   VSyncWidth   = 5,
  parameter logic SyncPolarity = 1'b1,
  parameter int   IslandStart  = 1300,
  parameter int   MaxPackets   = 2
) (
  input logic               clk,
  input logic               rst_n,
  h14tx_timings_gen_if.master bus
);

  if (IslandStart < ActiveWidth + 4) begin : g_chk_island_start
    $fatal(1, "IslandStart must be at least ActiveWidth+4");
  end
  if (IslandStart + 12 + PacketLen*MaxPackets + 4 > FrameWidth - 10) begin : g_chk_island_end
    $fatal(1, "island does not fit before the video preamble");
  end
  if (HSyncStart + HSyncWidth > FrameWidth) begin : g_chk_hsync
    $fatal(1, "hsync exceeds the line");
  end
  if (VSyncStart + VSyncWidth > FrameHeight) begin : g_chk_vsync
    $fatal(1, "vsync exceeds the frame");
  end
  if (MaxPackets < 1 || MaxPackets > 18) begin : g_chk_maxpk
    $fatal(1, "MaxPackets must be in 1..18");
  end

  localparam logic [BitWidth-1:0]  XLast  = BitWidth'(FrameWidth-1);
  localparam logic [BitHeight-1:0] YLast  = BitHeight'(FrameHeight-1);
  localparam logic [BitWidth-1:0]  XAct   = BitWidth'(ActiveWidth);
  localparam logic [BitHeight-1:0] YAct   = BitHeight'(ActiveHeight);
  localparam logic [BitHeight-1:0] YGEnd  = BitHeight'(ActiveHeight-1);
  localparam logic [BitWidth-1:0]  XVPre  = BitWidth'(FrameWidth-10);
  localparam logic [BitWidth-1:0]  XVGrd  = BitWidth'(FrameWidth-2);
  localparam logic [BitWidth:0]    HsB    = (BitWidth+1)'(HSyncStart);
  localparam logic [BitWidth:0]    HsE    = (BitWidth+1)'(HSyncStart+HSyncWidth);
  localparam logic [BitHeight:0]   VsB    = (BitHeight+1)'(VSyncStart);
  localparam logic [BitHeight:0]   VsE    = (BitHeight+1)'(VSyncStart+VSyncWidth);

  logic [BitWidth-1:0]  x_q, x_d;
  logic [BitHeight-1:0] y_q, y_d;
  period_t              timings_q, timings_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 frame_start_q, frame_start_d;
  logic                 guard_line;
  logic                 isl_act_d, grant_q, pstart_q;
  period_t              isl_per_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      timings_q     <= VideoActive;
      hsync_q       <= ~SyncPolarity;
      vsync_q       <= ~SyncPolarity;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      timings_q     <= timings_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.enable) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  h14tx_island_sched #(
    .BitWidth    (BitWidth),
    .IslandStart (IslandStart),
    .MaxPackets  (MaxPackets)
  ) u_island (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (bus.enable),
    .x_d            (x_d),
    .island_req     (bus.island_req),
    .island_packets (bus.island_packets),
    .isl_act_d      (isl_act_d),
    .isl_per_d      (isl_per_d),
    .grant_q        (grant_q),
    .pstart_q       (pstart_q)
  );

  // Every registered output is derived from the next counter values so it lines up with x/y.
  always_comb begin
    guard_line = (y_d < YGEnd) || (y_d == YLast);
    timings_d  = Control;
    if (x_d < XAct && y_d < YAct)          timings_d = VideoActive;
    else if (isl_act_d)                    timings_d = isl_per_d;
    else if (guard_line && x_d >= XVGrd)   timings_d = VideoGuard;
    else if (guard_line && x_d >= XVPre)   timings_d = VideoPreamble;
    hsync_d = ({1'b0, x_d} >= HsB && {1'b0, x_d} < HsE) ? SyncPolarity : ~SyncPolarity;
    vsync_d = ({1'b0, y_d} >= VsB && {1'b0, y_d} < VsE) ? SyncPolarity : ~SyncPolarity;
    frame_start_d = bus.enable ? (x_d == '0 && y_d == '0) : frame_start_q;
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.timings      = timings_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.island_grant = grant_q & bus.enable;
  assign bus.packet_start = pstart_q & bus.enable;
  assign bus.frame_start  = frame_start_q & bus.enable;

endmodule
